// File: rtl/wb_trace_uart.sv
// Write-back trace port: queues strobed 16-bit values and sends each as two 8N1 bytes, high byte first.
// Optional build macro WB_TRACE_FILTER_EN drops strobes whose value repeats the last accepted one.
module wb_trace_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              wbValue,
  input  logic                     wbStrobe,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q;
  logic [15:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q;
  logic [BAUD_W-1:0]  baud_q;
  logic [2:0]         bit_q;
  logic [2:0]         bit_nxt;
  logic [15:0]        hold_q;
  logic               hi_q;
  logic               tx_q, busy_q;
  logic               cand, full, pop, push, baud_end;
  logic [7:0]         cur_byte;

`ifdef WB_TRACE_FILTER_EN
  logic [15:0] last_q;
  logic        have_last_q;

  assign cand = wbStrobe && (!have_last_q || (wbValue != last_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else if (push) begin
      last_q      <= wbValue;
      have_last_q <= 1'b1;
    end
  end
`else
  assign cand = wbStrobe;
`endif

  // A pop frees a slot on the same edge, so a full FIFO still takes the write.
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign push     = cand && (!full || pop);
  assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign cur_byte = hi_q ? hold_q[15:8] : hold_q[7:0];
  assign bit_nxt  = bit_q + 3'd1;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= wbValue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (cand && full && !pop)
        overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      hi_q    <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            hold_q  <= mem_q[rd_ptr_q];
            hi_q    <= 1'b1;
            baud_q  <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= cur_byte[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_nxt;
              tx_q  <= cur_byte[bit_nxt];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            // High byte done: chain straight into the low byte's start bit.
            if (hi_q) begin
              hi_q    <= 1'b0;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_trace_uart.sv
// Directed bench for wb_trace_uart with CLKS_PER_BIT=4, DEPTH=4 and a sampling UART receiver.
module tb_wb_trace_uart;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbStrobe = 1'b0;
  logic [15:0] wbValue = '0;
  logic        tx, busy, overflow;
  logic [2:0]  count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  logic [7:0]  rx_q [$];
  int unsigned rx_t [$];
  logic        rx_abort;
  logic [7:0]  rx_b;
  int unsigned rx_t0;

  logic [15:0] wrap_vals [10] = '{16'h0102, 16'h8001, 16'hFFFF, 16'h0000, 16'h7E81,
                                  16'h3C3C, 16'hDEAD, 16'hBEEF, 16'h1248, 16'h55AA};
  logic [15:0] full_vals [6]  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h1234};

  wb_trace_uart #(.CLKS_PER_BIT(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .wbValue  (wbValue),
    .wbStrobe (wbStrobe),
    .tx       (tx),
    .busy     (busy),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_skip(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) rx_abort = 1'b1;
    end
  endtask

  // Receiver: start seen at negedge s, bits sampled at s+1+4k (one and a half cycles into each bit).
  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        rx_abort = 1'b0;
        rx_t0    = cyc;
        rx_b     = '0;
        rx_skip(1);
        if (!rx_abort) check("rx_start_bit", {31'd0, tx}, 32'd0);
        for (int unsigned b = 0; b < 8; b++) begin
          rx_skip(4);
          rx_b[b] = tx;
        end
        rx_skip(4);
        if (!rx_abort) begin
          check("rx_stop_bit", {31'd0, tx}, 32'd1);
          rx_q.push_back(rx_b);
          rx_t.push_back(rx_t0);
        end
      end
    end
  end

  task automatic get_word(input string tag, input logic [15:0] exp, output int unsigned t_hi);
    int unsigned k;
    logic [7:0]  hi, lo;
    int unsigned th, tl;
    k = 0;
    t_hi = 0;
    while (rx_q.size() < 2 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (rx_q.size() < 2) begin
      check({tag, "_timeout"}, rx_q.size(), 32'd2);
    end else begin
      hi = rx_q.pop_front();
      lo = rx_q.pop_front();
      th = rx_t.pop_front();
      tl = rx_t.pop_front();
      check(tag, {16'd0, hi, lo}, {16'd0, exp});
      check({tag, "_bytegap"}, tl - th, 32'd40);
      t_hi = th;
    end
  endtask

  task automatic wait_idle();
    int unsigned k;
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    wbValue  = v;
    wbStrobe = 1'b1;
    @(negedge clk);
    wbStrobe = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned t_prev, t_cur, bcyc, peak, k;

    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // Single word 0xA55A
    strobe(16'hA55A);
    check("t1_count_edgeN", {29'd0, count}, 32'd1);
    check("t1_busy_edgeN", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t1_count_pop", {29'd0, count}, 32'd0);
    check("t1_busy_rise", {31'd0, busy}, 32'd1);
    check("t1_tx_fall", {31'd0, tx}, 32'd0);
    bcyc = 1;
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge clk);
      if (busy === 1'b1) bcyc++;
      k++;
    end
    check("t1_busy_cycles", bcyc, 32'd80);
    check("t1_count_end", {29'd0, count}, 32'd0);
    get_word("t1_word", 16'hA55A, t_cur);

    // Burst of six strobes into an empty FIFO
    check("t2_ovf_pre", {31'd0, overflow}, 32'd0);
    peak = 0;
    for (int unsigned i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (count > peak) peak = count;
      wbValue  = 16'(i);
      wbStrobe = 1'b1;
    end
    @(negedge clk);
    wbStrobe = 1'b0;
    if (count > peak) peak = count;
    check("t2_overflow", {31'd0, overflow}, 32'd1);
    check("t2_count", {29'd0, count}, 32'd4);
    check("t2_peak", peak, 32'd4);
    t_prev = 0;
    for (int unsigned i = 1; i <= 5; i++) begin
      get_word("t2_word", 16'(i), t_cur);
      if (i > 1) check("t2_word_period", t_cur - t_prev, 32'd81);
      t_prev = t_cur;
    end
    repeat (100) @(negedge clk);
    check("t2_no_sixth", rx_q.size(), 32'd0);
    check("t2_count_end", {29'd0, count}, 32'd0);

    // Full FIFO with a write on the pop edge
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      wbValue  = full_vals[i];
      wbStrobe = 1'b1;
    end
    @(negedge clk);
    wbStrobe = 1'b0;
    check("t3_full", {29'd0, count}, 32'd4);
    check("t3_ovf_full", {31'd0, overflow}, 32'd0);
    wait_idle();
    check("t3_idle", {31'd0, busy}, 32'd0);
    check("t3_idle_count", {29'd0, count}, 32'd4);
    wbValue  = 16'h1234;
    wbStrobe = 1'b1;
    @(negedge clk);
    wbStrobe = 1'b0;
    check("t3_count_stays", {29'd0, count}, 32'd4);
    check("t3_ovf_stays", {31'd0, overflow}, 32'd0);
    check("t3_busy_again", {31'd0, busy}, 32'd1);
    for (int unsigned i = 0; i < 6; i++) get_word("t3_word", full_vals[i], t_cur);
    wait_idle();

    // Async reset during a data bit
    for (int unsigned i = 1; i <= 6; i++) begin
      @(negedge clk);
      wbValue  = 16'hA000 + 16'(i);
      wbStrobe = 1'b1;
    end
    @(negedge clk);
    wbStrobe = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_pre_busy", {31'd0, busy}, 32'd1);
    check("t4_pre_count", {29'd0, count}, 32'd4);
    check("t4_pre_ovf", {31'd0, overflow}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_tx", {31'd0, tx}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_count", {29'd0, count}, 32'd0);
    check("t4_ovf", {31'd0, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    rx_q.delete();
    rx_t.delete();
    strobe(16'h00FF);
    get_word("t4_after", 16'h00FF, t_cur);
    wait_idle();

    // Pointer wrap: ten words, one at a time
    for (int unsigned i = 0; i < 10; i++) begin
      strobe(wrap_vals[i]);
      get_word("t5_word", wrap_vals[i], t_cur);
      wait_idle();
    end
    check("t5_count_end", {29'd0, count}, 32'd0);

    // Duplicate filter
    strobe(16'h0007);
    repeat (2) @(negedge clk);
    strobe(16'h0007);
    repeat (2) @(negedge clk);
    strobe(16'h0008);
    repeat (2) @(negedge clk);
    strobe(16'h0007);
    get_word("t6_word0", 16'h0007, t_cur);
`ifndef WB_TRACE_FILTER_EN
    get_word("t6_word_dup", 16'h0007, t_cur);
`endif
    get_word("t6_word1", 16'h0008, t_cur);
    get_word("t6_word2", 16'h0007, t_cur);
    repeat (150) @(negedge clk);
    check("t6_no_extra", rx_q.size(), 32'd0);
    check("t6_busy_end", {31'd0, busy}, 32'd0);
    check("t6_ovf", {31'd0, overflow}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
